// File: rtl/mul_writeback_block.sv
// rtl/mul_writeback_block.sv - multiply tag realignment, MULW extension and RF write-port merge
module mul_writeback_block #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_word,
    input  logic        flush,
    input  logic        mul_valid,
    input  logic [63:0] mul_result,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [63:0] alu_wb_data,
    output logic        alu_wb_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [31:0] pend_mask,
    output logic        err
);

    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_kill;
    logic [LAT-1:0] tag_word;
    logic [4:0]     tag_rd [LAT];

    logic        arr_vld;
    logic        arr_kill;
    logic        arr_word;
    logic [4:0]  arr_rd;
    logic        arr_live;
    logic [63:0] mul_wdata;
    logic        alu_take;
    logic [31:0] pend_next;

    assign arr_vld  = tag_vld[LAT-1];
    assign arr_kill = tag_kill[LAT-1];
    assign arr_word = tag_word[LAT-1];
    assign arr_rd   = tag_rd[LAT-1];
    assign arr_live = arr_vld & ~arr_kill & (arr_rd != 5'd0);

    // The multiplier cannot stall, so the ALU yields on any live arrival,
    // decided from the tag pipe alone.
    assign alu_wb_ready = ~arr_live;
    assign alu_take     = alu_wb_valid & alu_wb_ready;
    assign mul_wdata    = arr_word ? {{32{mul_result[31]}}, mul_result[31:0]} : mul_result;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tag_vld  <= '0;
            tag_kill <= '0;
            tag_word <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_rd[i] <= 5'd0;
            end
        end else begin
            // Killed tags keep vld so the still-arriving result is expected.
            for (int i = LAT - 1; i > 0; i--) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_kill[i] <= tag_kill[i-1] | (flush & tag_vld[i-1]);
                tag_word[i] <= tag_word[i-1];
                tag_rd[i]   <= tag_rd[i-1];
            end
            tag_vld[0]  <= issue_valid;
            tag_kill[0] <= flush & issue_valid;
            tag_word[0] <= issue_word;
            tag_rd[0]   <= issue_rd;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 64'd0;
        end else if (arr_live) begin
            rf_we <= mul_valid;
            if (mul_valid) begin
                rf_waddr <= arr_rd;
                rf_wdata <= mul_wdata;
            end
        end else if (alu_take) begin
            rf_we    <= (alu_wb_rd != 5'd0);
            rf_waddr <= alu_wb_rd;
            rf_wdata <= alu_wb_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        pend_next = pend_mask;
        if (arr_live) begin
            pend_next[arr_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pend_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            pend_next = '0;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend_mask <= '0;
            err       <= 1'b0;
        end else begin
            pend_mask <= pend_next;
            err <= err | (arr_vld & ~mul_valid) | (~arr_vld & mul_valid)
                       | (issue_valid & pend_mask[issue_rd]);
        end
    end

endmodule

// File: tb/tb_mul_writeback_block.sv
// tb/tb_mul_writeback_block.sv - scoreboard bench for mul_writeback_block
module tb_mul_writeback_block;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_word = 1'b0;
    logic        flush = 1'b0;
    logic        mul_valid = 1'b0;
    logic [63:0] mul_result = 64'd0;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_rd = 5'd0;
    logic [63:0] alu_wb_data = 64'd0;
    logic        alu_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        err;

    always #5 clk = ~clk;

    mul_writeback_block #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_word(issue_word),
        .flush(flush), .mul_valid(mul_valid), .mul_result(mul_result),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pend_mask(pend_mask), .err(err)
    );

    typedef struct { int arr; logic [4:0] rd; logic word; logic killed; } op_t;
    typedef struct { logic [4:0] addr; logic [63:0] data; } wr_t;

    op_t         inflight[$];
    wr_t         exp_q[$];
    logic [31:0] pend_m = '0;
    logic        err_m = 1'b0;
    logic        alu_hold = 1'b0;
    logic        alu_acc = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        d_iv, d_word, d_fl, d_mv, d_av;
    logic [4:0]  d_rd, d_ard;
    logic [63:0] d_res, d_adata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic arrival_due();
        foreach (inflight[i]) if (inflight[i].arr == cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_idle();
        d_iv = 0; d_rd = 0; d_word = 0; d_fl = 0; d_mv = 0; d_res = 0;
        d_av = 0; d_ard = 0; d_adata = 0;
    endtask

    // One cycle: check current outputs against the model, drive d_* inputs, advance the model.
    task automatic step();
        int          ai;
        logic        live;
        logic [63:0] r;
        @(posedge clk); #1;
        ai = -1;
        foreach (inflight[i]) if (inflight[i].arr == cyc) ai = i;
        live = (ai >= 0) && !inflight[ai].killed && (inflight[ai].rd != 5'd0);
        check("alu_wb_ready", alu_wb_ready, !live);
        check("pend_mask", pend_mask, pend_m);
        check("err", err, err_m);
        if (!alu_hold) begin
            alu_wb_valid = d_av; alu_wb_rd = d_ard; alu_wb_data = d_adata;
        end
        issue_valid = d_iv; issue_rd = d_rd; issue_word = d_word; flush = d_fl;
        mul_valid = d_mv; mul_result = d_res;
        alu_acc = 1'b0;
        if (live) begin
            if (d_mv) begin
                r = inflight[ai].word ? 64'($signed(d_res[31:0])) : d_res;
                exp_q.push_back(wr_t'{inflight[ai].rd, r});
            end
        end else if (alu_wb_valid) begin
            alu_acc = 1'b1;
            if (alu_wb_rd != 5'd0) exp_q.push_back(wr_t'{alu_wb_rd, alu_wb_data});
        end
        alu_hold = alu_wb_valid && !alu_acc;
        if (((ai >= 0) != d_mv) || (d_iv && pend_m[d_rd])) err_m = 1'b1;
        if (live) pend_m[inflight[ai].rd] = 1'b0;
        if (d_iv && d_rd != 5'd0) pend_m[d_rd] = 1'b1;
        if (d_fl) begin
            pend_m = '0;
            foreach (inflight[i]) if (inflight[i].arr > cyc) inflight[i].killed = 1'b1;
        end
        if (d_iv) inflight.push_back(op_t'{cyc + LAT, d_rd, d_word, d_fl});
        if (ai >= 0) inflight.delete(ai);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            d_mv = arrival_due();
            d_res = {$urandom, $urandom};
            step();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_valid = 0; flush = 0; mul_valid = 0; alu_wb_valid = 0;
        #2;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_waddr", rf_waddr, 5'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        check("rst_pend_mask", pend_mask, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_alu_wb_ready", alu_wb_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        inflight.delete(); exp_q.delete();
        pend_m = '0; err_m = 1'b0; alu_hold = 1'b0;
        cyc += 2;
    endtask

    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst_n && rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%h expected=none", rf_waddr, rf_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("wb_addr", rf_waddr, w.addr);
                    check("wb_data", rf_wdata, w.data);
                end
            end
        end
    end

    initial begin : driver
        set_idle();
        do_reset();

        for (int n = 0; n < 300; n++) begin
            set_idle();
            d_fl = ($urandom_range(0, 19) == 0);
            d_iv = ($urandom_range(0, 2) != 0);
            d_rd = 5'($urandom_range(0, 31));
            if (d_iv && pend_m[d_rd]) d_iv = 1'b0;
            d_word = 1'($urandom_range(0, 1));
            d_mv = arrival_due();
            d_res = {$urandom, $urandom};
            d_av = 1'($urandom_range(0, 1));
            d_ard = 5'($urandom_range(0, 31));
            d_adata = {$urandom, $urandom};
            step();
        end
        idle(LAT + 3);
        do_reset();

        set_idle(); d_iv = 1; d_rd = 5; step();
        idle(1);
        check("pend_rd5", pend_mask, 32'h0000_0020);
        set_idle(); d_mv = 1; d_res = 64'h1234; step();
        idle(1);
        check("mul_we", rf_we, 1'b1);
        check("mul_waddr", rf_waddr, 5'd5);
        check("mul_wdata", rf_wdata, 64'h1234);
        idle(1);

        set_idle(); d_iv = 1; d_rd = 7; d_word = 1; step();
        idle(1);
        set_idle(); d_mv = 1; d_res = 64'h0000_0000_8000_0001; step();
        idle(1);
        check("mulw_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0001);
        idle(1);

        set_idle(); d_iv = 1; d_rd = 6; step();
        idle(1);
        set_idle(); d_mv = 1; d_res = 64'h55; d_av = 1; d_ard = 3; d_adata = 64'hAA; step();
        check("alu_stalled", alu_acc, 1'b0);
        idle(1);
        check("alu_accepted", alu_acc, 1'b1);
        idle(2);

        set_idle(); d_iv = 1; d_rd = 9; step();
        set_idle(); d_fl = 1; step();
        set_idle(); d_mv = 1; d_res = 64'h99; step();
        check("flush_pend", pend_mask, 32'd0);
        idle(2);
        check("flush_no_err", err, 1'b0);

        set_idle(); d_iv = 1; d_rd = 0; step();
        idle(1);
        set_idle(); d_mv = 1; d_res = 64'h77; d_av = 1; d_ard = 12; d_adata = 64'hC0DE; step();
        check("rd0_alu_accepted", alu_acc, 1'b1);
        idle(2);

        set_idle(); d_iv = 1; d_rd = 10; step();
        do_reset();
        set_idle(); d_mv = 1; d_res = 64'h1; step();
        idle(3);
        check("spurious_err_sticky", err, 1'b1);

        do_reset();
        set_idle(); d_iv = 1; d_rd = 4; step();
        set_idle(); d_iv = 1; d_rd = 4; step();
        idle(LAT + 2);
        check("double_issue_err", err, 1'b1);
        idle(2);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
